// File: rtl/alu_issue_unit_pkg.sv
// Shared types and helpers for the ALU issue unit: op codes, FSM states
// and the result-capture rule applied to the raw ALU output.
package alu_issue_unit_pkg;

  // Op codes as presented on {s0,s1,s2}
  typedef enum logic [2:0] {
    OP_INC = 3'b000,
    OP_ASR = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_DEC = 3'b100,
    OP_AND = 3'b101,
    OP_OR  = 3'b110,
    OP_XOR = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } issue_state_e;

  // Logic ops leave ALU bit 4 undriven, so it carries no information
  function automatic logic op_is_logic(input alu_op_e op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
  endfunction

  // Clean bit 4 for logic ops; arithmetic ops keep carry/borrow as-is
  function automatic logic [4:0] capture_result(input alu_op_e op, input logic [4:0] res);
    logic [4:0] r;
    r = res;
    if (op_is_logic(op)) r[4] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/alu_issue_unit.sv
// Issue/collect wrapper around an external combinational 4-bit ALU.
// Registers one request onto the ALU, waits a settle window, captures the
// 5-bit result with a zero flag and hands it out over valid/ready.
// The low nibble of each result is kept as an accumulator for chaining.
module alu_issue_unit
  import alu_issue_unit_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [3:0]       req_a,
  input  logic [3:0]       req_b,
  input  logic             req_use_acc,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic             alu_s0,
  output logic             alu_s1,
  output logic             alu_s2,
  input  logic [4:0]       alu_res,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [4:0]       rsp_result,
  output logic             rsp_zero,
  output logic [CNT_W-1:0] ops_done
);

  // Counter just wide enough to hold SETTLE_CYCLES-1
  localparam int              SC_W        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);

  issue_state_e     state_q, state_d;
  logic [SC_W-1:0]  cnt_q, cnt_d;
  logic [3:0]       a_q, a_d;
  logic [3:0]       b_q, b_d;
  alu_op_e          op_q, op_d;
  logic [3:0]       acc_q, acc_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [4:0]       rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [CNT_W-1:0] ops_done_q, ops_done_d;
  logic [4:0]       cap;

  // Next-state and datapath update for the IDLE -> DRIVE -> RESP cycle
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    acc_d        = acc_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    ops_done_d   = ops_done_q;
    cap          = capture_result(op_q, alu_res);
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          a_d     = req_use_acc ? acc_q : req_a;
          b_d     = req_b;
          op_d    = alu_op_e'(req_op);
          cnt_d   = SETTLE_LOAD;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          rsp_result_d = cap;
          rsp_zero_d   = (cap[3:0] == 4'b0000);
          acc_d        = cap[3:0];
          rsp_valid_d  = 1'b1;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        // Return through IDLE so a new request is never taken in the release cycle
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ops_done_d  = ops_done_q + 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= OP_INC;
      acc_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      acc_q        <= acc_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      ops_done_q   <= ops_done_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_s0     = op_q[2];
  assign alu_s1     = op_q[1];
  assign alu_s2     = op_q[0];
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: two instances (settle 1 with a 2-bit counter,
// settle 3 with an 8-bit counter), each wired to an ALU stand-in.
module tb_alu_issue_unit;

  logic       clk;
  logic       rst_n;
  logic       req_valid   [2];
  logic       req_ready   [2];
  logic [2:0] req_op      [2];
  logic [3:0] req_a       [2];
  logic [3:0] req_b       [2];
  logic       req_use_acc [2];
  logic [3:0] alu_a       [2];
  logic [3:0] alu_b       [2];
  logic       alu_s0      [2];
  logic       alu_s1      [2];
  logic       alu_s2      [2];
  logic [4:0] alu_res     [2];
  logic       rsp_valid   [2];
  logic       rsp_ready   [2];
  logic [4:0] rsp_result  [2];
  logic       rsp_zero    [2];
  logic [7:0] ops_done    [2];
  logic [1:0] od0;
  logic [7:0] od1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 0;

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int wrap_of(input int d);
    return (d == 0) ? 4 : 256;
  endfunction

  // ALU stand-in: logic ops drive bit 4 high to represent the undriven output
  function automatic logic [4:0] alu_standin(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'b000:  return {1'b0, a} + 5'd1;
      3'b001:  return {1'b0, a[3], a[3:1]};
      3'b010:  return {1'b0, a} + {1'b0, b};
      3'b011:  return {1'b0, a} - {1'b0, b};
      3'b100:  return {1'b0, a} - 5'd1;
      3'b101:  return {1'b1, a & b};
      3'b110:  return {1'b1, a | b};
      default: return {1'b1, a ^ b};
    endcase
  endfunction

  // What the unit must report for an op
  function automatic logic [4:0] exp_result(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int ia, ib, r;
    ia = a;
    ib = b;
    case (op)
      3'b000:  r = ia + 1;
      3'b001:  r = {a[3], a[3:1]};
      3'b010:  r = ia + ib;
      3'b011:  r = (ia - ib) & 31;
      3'b100:  r = (ia - 1) & 31;
      3'b101:  r = a & b;
      3'b110:  r = a | b;
      default: r = a ^ b;
    endcase
    return 5'(r);
  endfunction

  alu_issue_unit #(.SETTLE_CYCLES(1), .CNT_W(2)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
    .req_a(req_a[0]), .req_b(req_b[0]), .req_use_acc(req_use_acc[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_s0(alu_s0[0]), .alu_s1(alu_s1[0]),
    .alu_s2(alu_s2[0]), .alu_res(alu_res[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]),
    .rsp_zero(rsp_zero[0]), .ops_done(od0)
  );

  alu_issue_unit #(.SETTLE_CYCLES(3), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
    .req_a(req_a[1]), .req_b(req_b[1]), .req_use_acc(req_use_acc[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_s0(alu_s0[1]), .alu_s1(alu_s1[1]),
    .alu_s2(alu_s2[1]), .alu_res(alu_res[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]),
    .rsp_zero(rsp_zero[1]), .ops_done(od1)
  );

  assign ops_done[0] = {6'b0, od0};
  assign ops_done[1] = od1;
  assign alu_res[0]  = alu_standin({alu_s0[0], alu_s1[0], alu_s2[0]}, alu_a[0], alu_b[0]);
  assign alu_res[1]  = alu_standin({alu_s0[1], alu_s1[1], alu_s2[1]}, alu_a[1], alu_b[1]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Transaction-level model: accepted op, response timeline, accumulator, count
  bit         m_ready [2];
  bit         m_rv    [2];
  int         m_wait  [2];
  logic [4:0] m_pend  [2];
  logic [4:0] m_res   [2];
  logic [3:0] m_acc   [2];
  int         m_done  [2];
  logic [3:0] m_a     [2];
  logic [3:0] m_b     [2];
  logic [2:0] m_op    [2];

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_ready[d] <= 1'b1; m_rv[d] <= 1'b0; m_wait[d] <= 0;
        m_pend[d] <= '0; m_res[d] <= '0; m_acc[d] <= '0; m_done[d] <= 0;
        m_a[d] <= '0; m_b[d] <= '0; m_op[d] <= '0;
      end else if (m_rv[d]) begin
        if (rsp_ready[d]) begin
          m_rv[d]    <= 1'b0;
          m_done[d]  <= (m_done[d] + 1) % wrap_of(d);
          m_ready[d] <= 1'b1;
        end
      end else if (m_wait[d] > 0) begin
        m_wait[d] <= m_wait[d] - 1;
        if (m_wait[d] == 1) begin
          m_res[d] <= m_pend[d];
          m_acc[d] <= m_pend[d][3:0];
          m_rv[d]  <= 1'b1;
        end
      end else if (m_ready[d] && req_valid[d]) begin
        m_ready[d] <= 1'b0;
        m_wait[d]  <= settle_of(d);
        m_a[d]     <= req_use_acc[d] ? m_acc[d] : req_a[d];
        m_b[d]     <= req_b[d];
        m_op[d]    <= req_op[d];
        m_pend[d]  <= exp_result(req_op[d], req_use_acc[d] ? m_acc[d] : req_a[d], req_b[d]);
      end
    end
  end

  // Every cycle, DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("req_ready%0d", d), req_ready[d], m_ready[d]);
        check($sformatf("rsp_valid%0d", d), rsp_valid[d], m_rv[d]);
        if (m_rv[d]) begin
          check($sformatf("rsp_result%0d", d), rsp_result[d], m_res[d]);
          check($sformatf("rsp_zero%0d", d), rsp_zero[d], m_res[d][3:0] == 4'b0);
        end
        check($sformatf("ops_done%0d", d), ops_done[d], m_done[d]);
        check($sformatf("alu_a%0d", d), alu_a[d], m_a[d]);
        check($sformatf("alu_b%0d", d), alu_b[d], m_b[d]);
        check($sformatf("alu_sel%0d", d), {alu_s0[d], alu_s1[d], alu_s2[d]}, m_op[d]);
      end
    end
  end

  // One complete transaction with literal expectations
  task automatic do_op(input int d, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input bit ua, input logic [4:0] exp, input int hold, input bit extra);
    int n;
    int lat;
    logic [7:0] pre;
    @(posedge clk); #1;
    req_valid[d] = 1'b1; req_op[d] = op; req_a[d] = a; req_b[d] = b; req_use_acc[d] = ua;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 30) begin @(posedge clk); #1; n++; end
    if (n >= 30) begin
      check("accept_timeout", 32'd1, 32'd0);
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 0;
    while (rsp_valid[d] !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    check($sformatf("latency%0d", d), lat, settle_of(d));
    if (lat >= 40) return;
    check($sformatf("lit_result%0d", d), rsp_result[d], exp);
    check($sformatf("lit_zero%0d", d), rsp_zero[d], exp[3:0] == 4'b0);
    check($sformatf("busy_ready%0d", d), req_ready[d], 1'b0);
    for (int i = 0; i < hold; i++) begin
      if (extra) begin req_valid[d] = 1'b1; req_a[d] = 4'hE; req_op[d] = 3'b010; end
      @(posedge clk); #1;
      check($sformatf("hold_valid%0d", d), rsp_valid[d], 1'b1);
      check($sformatf("hold_result%0d", d), rsp_result[d], exp);
      check($sformatf("hold_ready%0d", d), req_ready[d], 1'b0);
    end
    pre = ops_done[d];
    rsp_ready[d] = 1'b1;
    req_valid[d] = 1'b0;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    check($sformatf("rel_valid%0d", d), rsp_valid[d], 1'b0);
    check($sformatf("rel_count%0d", d), ops_done[d], (32'(pre) + 1) % wrap_of(d));
    check($sformatf("rel_ready%0d", d), req_ready[d], 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 0; req_op[d] = 0; req_a[d] = 0; req_b[d] = 0;
      req_use_acc[d] = 0; rsp_ready[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    for (int d = 0; d < 2; d++) begin
      check("rst_req_ready", req_ready[d], 1'b1);
      check("rst_rsp_valid", rsp_valid[d], 1'b0);
      check("rst_rsp_result", rsp_result[d], 5'b0);
      check("rst_rsp_zero", rsp_zero[d], 1'b0);
      check("rst_ops_done", ops_done[d], 8'd0);
      check("rst_alu_a", alu_a[d], 4'd0);
    end

    for (int d = 0; d < 2; d++) begin
      do_op(d, 3'b000, 4'b1111, 4'b0000, 0, 5'b1_0000, 0, 0);
      do_op(d, 3'b011, 4'b0101, 4'b0011, 0, 5'b0_0010, 0, 0);
      do_op(d, 3'b011, 4'b0011, 4'b0101, 0, 5'b1_1110, 0, 0);
      do_op(d, 3'b101, 4'b1111, 4'b1010, 0, 5'b0_1010, 0, 0);
      do_op(d, 3'b111, 4'b1111, 4'b1010, 0, 5'b0_0101, 0, 0);
      do_op(d, 3'b010, 4'b0011, 4'b0100, 0, 5'b0_0111, 0, 0);
      do_op(d, 3'b111, 4'b1010, 4'b0111, 1, 5'b0_0000, 0, 0);
      do_op(d, 3'b110, 4'b1001, 4'b0100, 0, 5'b0_1101, 5, 1);
      do_op(d, 3'b001, 4'b1000, 4'b0000, 0, 5'b0_1100, 0, 0);
      do_op(d, 3'b100, 4'b0000, 4'b0000, 0, 5'b1_1111, 2, 0);
    end

    // Reset while the settle-3 unit is in its drive window
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_op[1] = 3'b010; req_a[1] = 4'd9; req_b[1] = 4'd4; req_use_acc[1] = 0;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    check("drive_ready", req_ready[1], 1'b0);
    rst_n = 1'b0;
    #2;
    check("mid_rst_valid", rsp_valid[1], 1'b0);
    check("mid_rst_alu_a", alu_a[1], 4'd0);
    check("mid_rst_ops_done", ops_done[1], 8'd0);
    check("mid_rst_ready", req_ready[1], 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(1, 3'b010, 4'b0101, 4'b0001, 1, 5'b0_0001, 0, 0);

    // 2-bit counter wraps after four completions
    do_op(0, 3'b000, 4'd1, 4'd0, 0, 5'b0_0010, 0, 0);
    do_op(0, 3'b000, 4'd2, 4'd0, 0, 5'b0_0011, 0, 0);
    do_op(0, 3'b000, 4'd3, 4'd0, 0, 5'b0_0100, 0, 0);
    check("wrap_three", ops_done[0], 8'd3);
    do_op(0, 3'b000, 4'd4, 4'd0, 0, 5'b0_0101, 0, 0);
    check("wrap_zero", ops_done[0], 8'd0);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
